// File: rtl/cla_adder_pkg.sv
// Shared constants for the registered carry-lookahead adder.
// The adder is built from fixed-size lookahead groups.
package cla_adder_pkg;

  localparam int CLA_DEFAULT_WIDTH = 8;
  localparam int CLA_GROUP_SIZE    = 4;

endpackage : cla_adder_pkg

// File: rtl/cla_4bit.sv
// One 4-bit lookahead group: two-level carries from the group carry-in,
// plus group generate/propagate for the second lookahead level.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a flat sum-of-products of g/p and cin, with no chaining through lower carries.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;

  assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign gp = &w_p;

endmodule : cla_4bit

// File: rtl/cla_adder.sv
// WIDTH-bit two-level carry-lookahead adder with registered Sum/Cout.
// Operands are used combinationally; only the result is flopped (1-cycle latency).
module cla_adder
  import cla_adder_pkg::*;
#(
  parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NG = WIDTH / CLA_GROUP_SIZE;

  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_gcin;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  genvar gi;
  for (gi = 0; gi < NG; gi++) begin : g_group
    cla_4bit u_grp (
      .a   (A[gi*CLA_GROUP_SIZE +: CLA_GROUP_SIZE]),
      .b   (B[gi*CLA_GROUP_SIZE +: CLA_GROUP_SIZE]),
      .cin (w_gcin[gi]),
      .sum (w_sum[gi*CLA_GROUP_SIZE +: CLA_GROUP_SIZE]),
      .gg  (w_gg[gi]),
      .gp  (w_gp[gi])
    );
  end

  // Second level: every group carry-in is an independent product-of-terms over
  // GG/GP and Cin, so no group waits on the carry of the group below it.
  always_comb begin
    logic v_prod;
    logic v_c;
    w_gcin    = '0;
    w_gcin[0] = Cin;
    for (int k = 1; k <= NG; k++) begin
      v_prod = Cin;
      for (int m = 0; m < k; m++) begin
        v_prod = v_prod & w_gp[m];
      end
      v_c = v_prod;
      for (int j = 0; j < k; j++) begin
        v_prod = w_gg[j];
        for (int m = j + 1; m < k; m++) begin
          v_prod = v_prod & w_gp[m];
        end
        v_c = v_c | v_prod;
      end
      w_gcin[k] = v_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_gcin[NG];
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule : cla_adder

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: expected {Cout,Sum} pushed to a queue
// when operands are driven, popped and compared one clock later.
`timescale 1ns/1ps
module tb_cla_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] Sum;
  logic         Cout;

  logic [W:0]   exp_q[$];
  logic [W:0]   exp_v;
  logic [W:0]   got_v;
  int           checks;
  int           errors;

  cla_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic test_reset();
    rst = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {Cout, Sum};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, got_v, exp_v);
      end else
        $display("reset_hold[%0d]: {Cout,Sum}=%h", i, got_v);
    end
  endtask

  // First edge after deassertion must already produce a real sum.
  task automatic test_directed();
    logic [W-1:0] ta[5];
    logic [W-1:0] tb[5];
    logic         tc[5];
    ta = '{8'd0, 8'd15, 8'd255, 8'd255, 8'd170};
    tb = '{8'd0, 8'd1,  8'd1,   8'd255, 8'd85};
    tc = '{1'b0, 1'b0,  1'b0,   1'b1,   1'b1};
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      A = ta[i]; B = tb[i]; Cin = tc[i];
      exp_q.push_back(add_ref(ta[i], tb[i], tc[i]));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {Cout, Sum};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL directed[%0d] %0d+%0d+%0d: got %h expected %h",
                 i, ta[i], tb[i], tc[i], got_v, exp_v);
      end else
        $display("directed[%0d] %0d+%0d+%0d: {Cout,Sum}=%h", i, ta[i], tb[i], tc[i], got_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] req[2];
    req = '{{1'b0, 8'd127}, {1'b1, 8'd45}};
    A = 8'd100; B = 8'd27; Cin = 1'b0;
    exp_q.push_back(req[0]);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    got_v = {Cout, Sum};
    A = 8'd200; B = 8'd100; Cin = 1'b1;
    exp_q.push_back(req[1]);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL b2b[0] 100+27+0: got %h expected %h", got_v, exp_v);
    end else
      $display("b2b[0] 100+27+0: {Cout,Sum}=%h", got_v);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    got_v = {Cout, Sum};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL b2b[1] 200+100+1: got %h expected %h", got_v, exp_v);
    end else
      $display("b2b[1] 200+100+1: {Cout,Sum}=%h", got_v);
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    for (int i = 0; i < 1200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      A = ra; B = rb; Cin = rc;
      rst = (i == 600);
      exp_q.push_back(rst ? '0 : add_ref(ra, rb, rc));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {Cout, Sum};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random[%0d] %0d+%0d+%0d rst=%0d: got %h expected %h",
                 i, ra, rb, rc, rst, got_v, exp_v);
      end else
        $display("random[%0d] %0d+%0d+%0d rst=%0d: {Cout,Sum}=%h", i, ra, rb, rc, rst, got_v);
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; A = '0; B = '0; Cin = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cla_adder

// File: doc/cla_adder.md
CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand/sum width in bits, a multiple of 4.
REQ-002 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-004 The module SHALL have port A, input, WIDTH bits, meaning unsigned addend A.
REQ-005 The module SHALL have port B, input, WIDTH bits, meaning unsigned addend B.
REQ-006 The module SHALL have port Cin, input, 1 bit, meaning carry-in.
REQ-007 The module SHALL have port Sum, output, WIDTH bits, meaning registered sum bits of A+B+Cin.
REQ-008 The module SHALL have port Cout, output, 1 bit, meaning registered carry-out of A+B+Cin.
REQ-009 The module SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-010 {Cout,Sum} SHALL equal the (WIDTH+1)-bit unsigned value A+B+Cin, for every input combination.
REQ-011 Per-bit generate G[i]=A[i]&B[i] and propagate P[i]=A[i]^B[i]; Sum[i]=P[i]^C[i], with C[0]=Cin.
REQ-012 Carries SHALL be computed by lookahead, not ripple: inside each 4-bit group C[i+1]=G[i]|P[i]&C[i], expanded to two-level sum-of-products from group carry-in.
REQ-013 Each 4-bit group SHALL produce group generate GG and group propagate GP; group carry-ins SHALL be computed by a second lookahead level from GG/GP and Cin.
REQ-014 Cout SHALL equal the carry out of the most significant group.
REQ-015 Latency SHALL be exactly 1 cycle: inputs sampled at rising edge N appear on Sum/Cout after edge N and hold until the next edge.
REQ-016 No handshake; a new operand set SHALL be accepted every cycle (throughput 1/cycle).
REQ-017 Overflow SHALL wrap in Sum with the lost bit in Cout (e.g., 255+1 -> Sum=0, Cout=1).
REQ-018 Inputs SHALL be unregistered; only Sum and Cout are flopped.

Reset
REQ-019 When rst=1 at a rising edge, Sum SHALL become 0 and Cout SHALL become 0, regardless of A/B/Cin.
REQ-020 Reset SHALL take precedence over any addition on the same edge; the first result after deassertion is from inputs sampled on the first edge with rst=0.
REQ-021 Reset mid-stream SHALL discard the in-flight result; no other state exists.

Structure
REQ-022 A shared package SHALL hold the default width constant (8) and the group-size constant (4).
REQ-023 One sub-module, cla_4bit, SHALL implement a 4-bit lookahead group (inputs a, b, cin; outputs sum, gg, gp); cla_adder SHALL instantiate WIDTH/4 of them plus the second-level lookahead and output registers.

Verification
REQ-024 rst=1 for 2 cycles with A=8'hFF, B=8'hFF, Cin=1 -> Sum=0, Cout=0 while reset held.
REQ-025 A=0, B=0, Cin=0 -> one cycle later Sum=0, Cout=0.
REQ-026 A=15, B=1, Cin=0 -> Sum=16, Cout=0 (carry crosses group boundary).
REQ-027 A=255, B=1, Cin=0 -> Sum=0, Cout=1; A=255, B=255, Cin=1 -> Sum=255, Cout=1.
REQ-028 Back-to-back inputs each cycle (e.g., 100+27+0, then 200+100+1) -> Sum=127/Cout=0, then Sum=45/Cout=1, on consecutive cycles.
REQ-029 At least 1000 random A, B, Cin values -> {Cout,Sum} matches A+B+Cin delayed by one cycle, with rst asserted once mid-run clearing outputs to 0.
